// File: rtl/apb_completer_regfile.sv
// APB completer backed by a DEPTH x 32-bit register file.
// A fixed number of wait states is inserted before PREADY.
module apb_completer_regfile #(
    parameter int unsigned DEPTH         = 16,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES   = 0,
    parameter logic [31:0] DEFAULT_RDATA = 32'h0
) (
    input  logic        clk,
    input  logic        preset,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    output logic        pready,
    output logic [31:0] prdata
);
    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam logic [3:0]  WaitLd = 4'(WAIT_CYCLES);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pready_q, pready_d;
    logic [31:0]   prdata_q, prdata_d;
    logic [31:2]   addr_q, addr_d;
    logic          write_q, write_d;
    logic [31:0]   mem_q [DEPTH];

    logic [31:2]   dec_addr;
    logic          in_range;
    logic [IdxW-1:0] idx;
    logic [31:0]   rd_word;
    logic          commit;
    logic          unused_paddr;

    assign unused_paddr = ^paddr[1:0];

    // In IDLE the live bus address is decoded so zero-wait reads can load prdata at setup.
    assign dec_addr = (state_q == StIdle) ? paddr[31:2] : addr_q;
    assign in_range = (dec_addr[31:IdxW+2] == BASE_ADDR[31:IdxW+2]);
    assign idx      = dec_addr[IdxW+1:2];
    assign rd_word  = in_range ? mem_q[idx] : DEFAULT_RDATA;

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (psel && !penable) state_d = StAccess;
            StAccess: if (!psel || (pready_q && penable)) state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        pready_d = pready_q;
        prdata_d = prdata_q;
        addr_d   = addr_q;
        write_d  = write_q;
        commit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                pready_d = 1'b0;
                if (psel && !penable) begin
                    addr_d   = paddr[31:2];
                    write_d  = pwrite;
                    cnt_d    = WaitLd;
                    pready_d = (WAIT_CYCLES == 0);
                end
            end
            StAccess: begin
                if (!psel) begin
                    pready_d = 1'b0;
                end else if (!pready_q) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) pready_d = 1'b1;
                end else if (penable) begin
                    commit   = write_q && in_range;
                    pready_d = 1'b0;
                end
            end
        endcase
        // Read data is captured on the edge that raises pready.
        if (pready_d && !pready_q && !write_d) prdata_d = rd_word;
    end

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            cnt_q    <= '0;
            pready_q <= 1'b0;
            prdata_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            if (commit) mem_q[idx] <= pwdata;
        end
    end

    assign pready = pready_q;
    assign prdata = prdata_q;

endmodule
